axi2dcc_lite_arbiter: RTL and testbench
=======================================

# axi2dcc_lite_arbiter

Two-requester AXI4-Lite master arbiter that shares the single register port of the axi2dcc slave between two on-chip command sources. Each source issues single-beat read or write commands over a valid/ready interface. The block grants sources round-robin and runs exactly one AXI4-Lite transaction at a time on the master port. It returns read data and response per source with a one-cycle done pulse.

## Interface
Parameters:
- C_ADDR_WIDTH, 4, byte address width of the register port; 4 registers at offsets 0x0, 0x4, 0x8, 0xC.
- C_DATA_WIDTH, 32, data width; only 32 is supported.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- REQ_VALID  in  2  per-source command valid; bit n is source n.
- REQ_READY  out  2  per-source command accept. At most one bit is high.
- REQ_WE  in  2  per-source command type: 1 = write, 0 = read.
- REQ_ADDR  in  2*C_ADDR_WIDTH  per-source address; source n uses slice [n*C_ADDR_WIDTH +: C_ADDR_WIDTH].
- REQ_WDATA  in  2*C_DATA_WIDTH  per-source write data, sliced the same way.
- DONE  out  2  per-source completion pulse, one cycle wide.
- RDATA  out  C_DATA_WIDTH  read data of the completing command; held until the next completion.
- RESP  out  2  AXI response of the completing command; held until the next completion.
- M_AXI_AWADDR / AWPROT / AWVALID / AWREADY: AXI4-Lite write address channel, with widths C_ADDR_WIDTH / 3 / 1 / 1.
- M_AXI_WDATA / WSTRB / WVALID / WREADY: write data channel, with widths C_DATA_WIDTH / 4 / 1 / 1.
- M_AXI_BRESP / BVALID / BREADY: write response channel, with widths 2 / 1 / 1.
- M_AXI_ARADDR / ARPROT / ARVALID / ARREADY: read address channel, with widths C_ADDR_WIDTH / 3 / 1 / 1.
- M_AXI_RDATA / RRESP / RVALID / RREADY: read data channel, with widths C_DATA_WIDTH / 2 / 1 / 1.

## Operation
**FSM states:** IDLE, WR (AW and W phase), WR_RESP, RD_ADDR, RD_DATA.

**IDLE:**
- REQ_READY is combinational and is driven only in IDLE.
- Arbitration:
  - One source valid: that source is granted.
  - Both sources valid: grant the source that was not granted last.
  - Last-grant pointer resets to 1, so source 0 wins the first tie.
- On a grant:
  - Capture WE, ADDR and WDATA into command registers.
  - Record the grant index.
  - Update the last-grant pointer.
  - Go to WR if WE = 1, otherwise go to RD_ADDR.

**WR:**
- AWVALID and WVALID are both high on entry.
- Each valid drops independently after its own handshake; the two handshakes may occur in either order or in the same cycle.
- When both handshakes are done, go to WR_RESP.

**WR_RESP:**
- BREADY = 1.
- On the BVALID handshake, capture BRESP and go to IDLE.

**RD_ADDR:**
- ARVALID = 1.
- On the ARREADY handshake, go to RD_DATA.

**RD_DATA:**
- RREADY = 1.
- On the RVALID handshake, capture RDATA and RRESP and go to IDLE.

**Completion:**
- In the cycle after the B or R handshake, DONE[grant] = 1 and RDATA/RESP carry the captured values.
- For writes, RDATA is 0.

**Fixed AXI fields:**
- AWPROT and ARPROT are 3'b000.
- WSTRB is 4'hF.
- AWADDR and ARADDR come from the command register, with bits [1:0] forced to 0.

**Ordering:**
- Only one transaction is outstanding at any time.
- Valid and data signals hold stable until their handshake, per AXI.

## Timing
**Reset values** (any cycle with ARESET high):
- All M_AXI valids and readies = 0.
- REQ_READY = 0.
- DONE = 0.
- RDATA = 0, RESP = 0.
- FSM = IDLE.
- Last-grant pointer = 1.

**Reset mid-transaction:** the transaction is abandoned with no DONE; the slave is reset in the same cycle.

**Minimum write latency** (AWREADY and WREADY high, BVALID one cycle after the handshake):
- Cycle T: accept.
- T+1: AW/W handshake.
- T+2: B handshake.
- T+3: DONE.

**Minimum read latency:**
- Cycle T: accept.
- T+1: AR handshake.
- T+2: R handshake.
- T+3: DONE.

**Back-to-back:**
- The FSM is in IDLE in the DONE cycle, so a new command can be accepted in that same cycle.
- Sustained throughput is one command per 3 cycles minimum.

**Simultaneous events:**
- A source that drops REQ_VALID before being granted loses nothing; it was never accepted.
- A source whose REQ_VALID is high in its own DONE cycle may be re-granted in that cycle only if the other source is idle.

## Test plan
- **Single write then read:**
  - Stimulus: source 0 writes 0x00000001 to 0x0, then reads 0x0.
  - Required: DONE[0] at T+3 each time; RESP = 0; RDATA = 0x00000001.
- **Four-register sweep:**
  - Stimulus: source 1 writes 0x1..0x4 to 0x0/0x4/0x8/0xC, then reads all four.
  - Required: the reads return 0x1, 0x2, 0x3, 0x4 in order; only DONE[1] pulses.
- **Tie arbitration:**
  - Stimulus: both sources hold REQ_VALID from reset for 3 commands each.
  - Required: grant order 0, 1, 0, 1, 0, 1; REQ_READY is never 2'b11.
- **Independent AW/W ordering:**
  - Stimulus: slave delays AWREADY 3 cycles with WREADY = 1, then the reverse.
  - Required: WVALID drops after its handshake while AWVALID holds; exactly one B handshake; DONE once per write.
- **Slave error:**
  - Stimulus: slave returns RRESP = 2'b10 with RDATA = 0xDEADBEEF.
  - Required: RESP = 2'b10 and RDATA = 0xDEADBEEF in the DONE cycle.
- **Reset in WR_RESP:**
  - Stimulus: assert ARESET for 1 cycle while in WR_RESP.
  - Required: next cycle has all valids 0, BREADY 0, no DONE; the next command from source 0 completes normally.

Source files
------------

// File: rtl/axi2dcc_lite_arbiter.sv
// Two-source round-robin arbiter that funnels single-beat read/write commands
// onto one AXI4-Lite master port, one transaction at a time.
module axi2dcc_lite_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  // Command side: a source's command is accepted in the cycle where
  // REQ_VALID[n] and REQ_READY[n] are both high; the source holds WE/ADDR/WDATA
  // stable while REQ_VALID[n] is high and unaccepted. AXI channels follow the
  // same rule: a transfer happens on the edge where VALID and READY are both high.
  input  logic [1:0]                  REQ_VALID,
  output logic [1:0]                  REQ_READY,
  input  logic [1:0]                  REQ_WE,
  input  logic [2*C_ADDR_WIDTH-1:0]   REQ_ADDR,
  input  logic [2*C_DATA_WIDTH-1:0]   REQ_WDATA,
  output logic [1:0]                  DONE,
  output logic [C_DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                  RESP,
  output logic [C_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [C_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [3:0]                  M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [C_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [C_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  output logic [2:0]                  DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4
  } state_e;

  localparam logic [C_ADDR_WIDTH-1:0] ADDR_WORD_MASK = ~C_ADDR_WIDTH'(3);

  state_e                    state_q, state_d;
  logic [C_ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
  logic [C_DATA_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic                      grant_q, grant_d;
  logic                      last_q, last_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic [1:0]                done_q, done_d;
  logic [C_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                resp_q, resp_d;

  logic                      grant_any;
  logic                      grant_idx;
  logic [C_ADDR_WIDTH-1:0]   sel_addr;
  logic [C_DATA_WIDTH-1:0]   sel_wdata;

  // On a tie the source that did not win last time is picked.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    if (REQ_VALID == 2'b11) begin
      grant_any = 1'b1;
      grant_idx = ~last_q;
    end else if (REQ_VALID[0]) begin
      grant_any = 1'b1;
      grant_idx = 1'b0;
    end else if (REQ_VALID[1]) begin
      grant_any = 1'b1;
      grant_idx = 1'b1;
    end
  end

  assign sel_addr  = grant_idx ? REQ_ADDR[C_ADDR_WIDTH +: C_ADDR_WIDTH]
                               : REQ_ADDR[0 +: C_ADDR_WIDTH];
  assign sel_wdata = grant_idx ? REQ_WDATA[C_DATA_WIDTH +: C_DATA_WIDTH]
                               : REQ_WDATA[0 +: C_DATA_WIDTH];

  always_comb begin
    state_d     = state_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    grant_d     = grant_q;
    last_d      = last_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    done_d      = 2'b00;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          cmd_addr_d  = sel_addr & ADDR_WORD_MASK;
          cmd_wdata_d = sel_wdata;
          grant_d     = grant_idx;
          last_d      = grant_idx;
          if (REQ_WE[grant_idx]) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        // AW and W complete independently; leave once both have transferred.
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
          state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (M_AXI_BVALID) begin
          resp_d  = M_AXI_BRESP;
          rdata_d = '0;
          done_d  = grant_q ? 2'b10 : 2'b01;
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (M_AXI_ARREADY) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (M_AXI_RVALID) begin
          resp_d  = M_AXI_RRESP;
          rdata_d = M_AXI_RDATA;
          done_d  = grant_q ? 2'b10 : 2'b01;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      done_q      <= 2'b00;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  // Outputs are masked by ARESET so the reset cycle itself shows idle values,
  // even when reset lands in the middle of a transaction.
  assign REQ_READY = (state_q == S_IDLE && grant_any && !ARESET)
                     ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;

  assign M_AXI_AWADDR  = cmd_addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q & ~ARESET;
  assign M_AXI_WDATA   = cmd_wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q & ~ARESET;
  assign M_AXI_BREADY  = (state_q == S_WR_RESP) & ~ARESET;
  assign M_AXI_ARADDR  = cmd_addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state_q == S_RD_ADDR) & ~ARESET;
  assign M_AXI_RREADY  = (state_q == S_RD_DATA) & ~ARESET;

  assign DONE      = done_q & {2{~ARESET}};
  assign RDATA     = ARESET ? '0 : rdata_q;
  assign RESP      = ARESET ? 2'b00 : resp_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_axi2dcc_lite_arbiter.sv
// Directed bench for axi2dcc_lite_arbiter: vector table of commands plus
// hand-written sequences for arbitration, AW/W skew, slave error and reset.
module tb_axi2dcc_lite_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]      req_valid, req_ready, req_we, done, resp;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   awaddr, araddr;
  logic [2:0]      awprot, arprot, dbg_state;
  logic            awvalid, awready, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rvalid, rready;
  logic [DW-1:0]   wdata, s_rdata;
  logic [3:0]      wstrb;
  logic [1:0]      bresp, rresp;

  axi2dcc_lite_arbiter #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
    .ACLK(clk), .ARESET(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .DONE(done), .RDATA(rdata), .RESP(resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .DBG_STATE(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  int aw_wait = 0, w_wait = 0;
  bit err_mode = 0, b_block = 0;
  logic [DW-1:0] mem [0:3];
  int aw_cnt = 0, w_cnt = 0;
  logic aw_got = 0, w_got = 0;
  logic [AW-1:0] aw_a;
  logic [DW-1:0] w_d;
  int aw_hs = 0, w_hs = 0, b_hs = 0, viol = 0;
  logic s_aw_now, s_w_now;
  logic [AW-1:0] s_a;
  logic [DW-1:0] s_d;
  int s_v;

  assign awready = (aw_cnt >= aw_wait);
  assign wready  = (w_cnt >= w_wait);
  assign arready = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 0; w_got <= 0;
      bvalid <= 0; bresp <= 0; rvalid <= 0; rresp <= 0; s_rdata <= 0;
    end else begin
      s_v = 0;
      s_aw_now = aw_got; s_a = aw_a; s_w_now = w_got; s_d = w_d;
      if (awvalid && aw_got) s_v++;
      if (wvalid && w_got) s_v++;
      if (awvalid && awready) begin
        s_aw_now = 1; s_a = awaddr; aw_cnt <= 0; aw_hs <= aw_hs + 1;
        if (awaddr[1:0] != 2'b00 || awprot != 3'b000) s_v++;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        s_w_now = 1; s_d = wdata; w_cnt <= 0; w_hs <= w_hs + 1;
        if (wstrb != 4'hF) s_v++;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if (s_aw_now && s_w_now && !b_block && !bvalid) begin
        mem[s_a[3:2]] <= s_d; bvalid <= 1; bresp <= 2'b00;
        s_aw_now = 0; s_w_now = 0;
      end
      aw_got <= s_aw_now; aw_a <= s_a; w_got <= s_w_now; w_d <= s_d;
      if (bvalid && bready) begin bvalid <= 0; b_hs <= b_hs + 1; end
      if (arvalid && arready) begin
        rvalid <= 1;
        if (araddr[1:0] != 2'b00 || arprot != 3'b000) s_v++;
        if (err_mode) begin s_rdata <= 32'hDEADBEEF; rresp <= 2'b10; end
        else begin s_rdata <= mem[araddr[3:2]]; rresp <= 2'b00; end
      end
      if (rvalid && rready) rvalid <= 0;
      viol <= viol + s_v;
    end
  end

  int aw_only_cyc = 0, w_only_cyc = 0;
  always @(negedge clk) begin
    if (awvalid && !wvalid) aw_only_cyc++;
    if (wvalid && !awvalid) w_only_cyc++;
  end

  // ---------------- scoreboard ----------------
  int n_total = 0, n_pass = 0;
  logic [1:0] exp_q[$];
  logic [1:0] got_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  // ---------------- driver ----------------
  task automatic run_cmd(input int src, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_rdata,
                         input logic [1:0] exp_resp, input int exp_lat, input string name);
    int t_acc, t_done;
    bit ok;
    @(negedge clk);
    req_we[src] = we;
    req_addr[src*AW +: AW] = addr;
    req_wdata[src*DW +: DW] = wd;
    req_valid[src] = 1'b1;
    ok = 0; t_acc = 0; t_done = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (req_ready[src]) begin ok = 1; t_acc = cyc; end
      else @(negedge clk);
    end
    if (!ok) begin
      fail_timeout({name, "_accept"});
      req_valid[src] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[src] = 1'b0;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (done != 2'b00) begin ok = 1; t_done = cyc; end
      else @(negedge clk);
    end
    if (!ok) begin
      fail_timeout({name, "_done"});
      return;
    end
    check({name, "_done_mask"}, done, (src == 1) ? 2'b10 : 2'b01);
    if (exp_lat >= 0) check({name, "_latency"}, t_done - t_acc, exp_lat);
    check({name, "_rdata"}, rdata, exp_rdata);
    check({name, "_resp"}, resp, exp_resp);
    @(negedge clk);
    check({name, "_done_one_cycle"}, done, 2'b00);
  endtask

  typedef struct {
    int             src;
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  exp_rdata;
    logic [1:0]     exp_resp;
    int             exp_lat;
  } vec_t;
  vec_t vecs[13];

  int cnt0, cnt1, dones, both_ready, n_acc, aw0, w0, b0, awo0, wo0;
  int acc_c[2];

  initial begin
    vecs[0]  = '{0, 1'b1, 4'h0, 32'h1,  32'h0,  2'b00, 3};
    vecs[1]  = '{0, 1'b0, 4'h0, 32'h0,  32'h1,  2'b00, 3};
    vecs[2]  = '{1, 1'b1, 4'h0, 32'h1,  32'h0,  2'b00, 3};
    vecs[3]  = '{1, 1'b1, 4'h4, 32'h2,  32'h0,  2'b00, 3};
    vecs[4]  = '{1, 1'b1, 4'h8, 32'h3,  32'h0,  2'b00, 3};
    vecs[5]  = '{1, 1'b1, 4'hC, 32'h4,  32'h0,  2'b00, 3};
    vecs[6]  = '{1, 1'b0, 4'h0, 32'h0,  32'h1,  2'b00, 3};
    vecs[7]  = '{1, 1'b0, 4'h4, 32'h0,  32'h2,  2'b00, 3};
    vecs[8]  = '{1, 1'b0, 4'h8, 32'h0,  32'h3,  2'b00, 3};
    vecs[9]  = '{1, 1'b0, 4'hC, 32'h0,  32'h4,  2'b00, 3};
    vecs[10] = '{0, 1'b0, 4'h7, 32'h0,  32'h2,  2'b00, 3};
    vecs[11] = '{1, 1'b1, 4'hB, 32'h33, 32'h0,  2'b00, 3};
    vecs[12] = '{0, 1'b0, 4'h8, 32'h0,  32'h33, 2'b00, 3};

    // Reset with both sources already requesting; then tie arbitration.
    rst = 1'b1; req_valid = 2'b11; req_we = 2'b00; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_done", done, 2'b00);
    check("rst_rdata_resp", {rdata, resp}, 34'h0);
    check("rst_axi_handshakes", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("rst_state", dbg_state, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt0 = 0; cnt1 = 0; dones = 0; both_ready = 0;
    for (int i = 0; i < 200 && dones < 6; i++) begin
      #1;
      if (req_ready == 2'b11) both_ready++;
      if (req_ready[0]) begin got_q.push_back(2'd0); cnt0++; end
      if (req_ready[1]) begin got_q.push_back(2'd1); cnt1++; end
      if (done != 2'b00) dones++;
      @(negedge clk);
      if (cnt0 == 3) req_valid[0] = 1'b0;
      if (cnt1 == 3) req_valid[1] = 1'b0;
    end
    req_valid = 2'b00;
    if (dones < 6) fail_timeout("tie_six_dones");
    check("tie_never_both_ready", both_ready, 0);
    for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 2'd0 : 2'd1);
    check("tie_grant_count", got_q.size(), 6);
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("tie_grant_order", got_q.pop_front(), exp_q.pop_front());
    repeat (3) @(negedge clk);

    // Main function from the vector table.
    for (int v = 0; v < 13; v++)
      run_cmd(vecs[v].src, vecs[v].we, vecs[v].addr, vecs[v].wdata,
              vecs[v].exp_rdata, vecs[v].exp_resp, vecs[v].exp_lat, $sformatf("vec%0d", v));

    // Back-to-back: source 0 alone is re-accepted in its own DONE cycle.
    @(negedge clk);
    req_we[0] = 1'b0; req_addr[0 +: AW] = 4'h4; req_valid[0] = 1'b1; n_acc = 0;
    for (int i = 0; i < 40 && n_acc < 2; i++) begin
      #1;
      if (req_ready[0]) begin acc_c[n_acc] = cyc; n_acc++; end
      @(negedge clk);
      if (n_acc == 2) req_valid[0] = 1'b0;
    end
    req_valid[0] = 1'b0;
    check("b2b_accepts", n_acc, 2);
    if (n_acc == 2) check("b2b_interval", acc_c[1] - acc_c[0], 3);
    repeat (6) @(negedge clk);

    // AWREADY delayed, WREADY immediate.
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; awo0 = aw_only_cyc; wo0 = w_only_cyc;
    aw_wait = 3; w_wait = 0;
    run_cmd(0, 1'b1, 4'h4, 32'hA5A5_0001, 32'h0, 2'b00, 6, "aw_late");
    check("aw_late_aw_hs", aw_hs - aw0, 1);
    check("aw_late_w_hs", w_hs - w0, 1);
    check("aw_late_b_hs", b_hs - b0, 1);
    check("aw_late_awvalid_alone", aw_only_cyc - awo0, 3);
    check("aw_late_wvalid_alone", w_only_cyc - wo0, 0);
    // WREADY delayed, AWREADY immediate.
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs; awo0 = aw_only_cyc; wo0 = w_only_cyc;
    aw_wait = 0; w_wait = 3;
    run_cmd(1, 1'b1, 4'h8, 32'hA5A5_0002, 32'h0, 2'b00, 6, "w_late");
    check("w_late_aw_hs", aw_hs - aw0, 1);
    check("w_late_w_hs", w_hs - w0, 1);
    check("w_late_b_hs", b_hs - b0, 1);
    check("w_late_wvalid_alone", w_only_cyc - wo0, 3);
    check("w_late_awvalid_alone", aw_only_cyc - awo0, 0);
    w_wait = 0;
    run_cmd(0, 1'b0, 4'h4, 32'h0, 32'hA5A5_0001, 2'b00, 3, "rb_aw_late");
    run_cmd(1, 1'b0, 4'h8, 32'h0, 32'hA5A5_0002, 2'b00, 3, "rb_w_late");

    // Slave error on a read.
    err_mode = 1;
    run_cmd(1, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 2'b10, 3, "slv_err");
    err_mode = 0;

    // Reset while waiting for B.
    b_block = 1;
    @(negedge clk);
    req_we[0] = 1'b1; req_addr[0 +: AW] = 4'h8; req_wdata[0 +: DW] = 32'h55; req_valid[0] = 1'b1;
    #1;
    check("rstwr_accept_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 20 && dbg_state != 3'd2; i++) @(negedge clk);
    check("rstwr_in_wr_resp", dbg_state, 3'd2);
    check("rstwr_bready_before", bready, 1'b1);
    rst = 1'b1;
    #1;
    check("rstwr_outputs_during_reset", {bready, done, rdata, resp}, 37'h0);
    @(negedge clk);
    rst = 1'b0; b_block = 0;
    #1;
    check("rstwr_valids_after", {awvalid, wvalid, arvalid, rready, bready}, 5'b0);
    check("rstwr_state_after", dbg_state, 3'd0);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (done != 2'b00) dones++;
      @(negedge clk);
    end
    check("rstwr_no_done", dones, 0);
    run_cmd(0, 1'b1, 4'h8, 32'h77, 32'h0, 2'b00, 3, "post_rst_wr");
    run_cmd(0, 1'b0, 4'h8, 32'h0, 32'h77, 2'b00, 3, "post_rst_rd");

    check("axi_protocol_violations", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
